// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serialising memory access unit:
// request sizes, FSM states and the DRAM byte-lane address mapping.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // DRAM holds one byte per word slot, so byte k lives at k << LANE_SHIFT.
    localparam int LANE_SHIFT = 2;

    function automatic logic [1:0] last_beat(size_e size);
        case (size)
            SIZE_BYTE: last_beat = 2'd0;
            SIZE_HALF: last_beat = 2'd1;
            default:   last_beat = 2'd3;
        endcase
    endfunction

    function automatic logic bad_request(size_e size, logic [1:0] addr_lsb);
        case (size)
            SIZE_BYTE: bad_request = 1'b0;
            SIZE_HALF: bad_request = addr_lsb[0];
            SIZE_WORD: bad_request = (addr_lsb != 2'b00);
            default:   bad_request = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data according to access size.
module load_extend
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (size)
            SIZE_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
            SIZE_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
            default:   data = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises 32-bit load/store requests into one byte-wide DRAM beat per byte,
// little-endian, and returns extended load data with a one-cycle response pulse.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata
);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    size_e                 size_q;
    logic                  sgn_q;
    logic [31:0]           wdata_q;
    logic [31:0]           raw_q;
    logic [1:0]            beat;
    logic [1:0]            last_q;

    logic [1:0]            beat_next;
    logic [ADDR_WIDTH-1:0] next_byte_addr;
    logic [31:0]           raw_next;
    logic [31:0]           ext_data;
    size_e                 req_size_e;

    assign req_size_e     = size_e'(req_size);
    assign req_ready      = (state == ST_IDLE) && !rst;
    assign beat_next      = beat + 2'd1;
    assign next_byte_addr = addr_q + ADDR_WIDTH'(beat_next);

    // Load data including the byte arriving on the current beat, so the final
    // beat's capture and the response can share one edge.
    always_comb begin
        raw_next = raw_q;
        raw_next[{beat, 3'b000} +: 8] = mem_rdata;
    end

    load_extend u_load_extend (
        .size (size_q),
        .sgn  (sgn_q),
        .raw  (raw_next),
        .data (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= SIZE_BYTE;
            sgn_q      <= 1'b0;
            wdata_q    <= '0;
            raw_q      <= '0;
            beat       <= '0;
            last_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        size_q  <= req_size_e;
                        sgn_q   <= req_signed;
                        wdata_q <= req_wdata;
                        raw_q   <= '0;
                        beat    <= '0;
                        last_q  <= last_beat(req_size_e);
                        if (bad_request(req_size_e, req_addr[1:0])) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_addr  <= req_addr << LANE_SHIFT;
                            mem_we    <= req_write;
                            mem_wdata <= req_write ? req_wdata[7:0] : 8'h00;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_q)
                        raw_q <= raw_next;
                    if (beat == last_q) begin
                        state      <= ST_DONE;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= write_q ? 32'h0 : ext_data;
                    end else begin
                        beat      <= beat_next;
                        mem_addr  <= next_byte_addr << LANE_SHIFT;
                        mem_wdata <= write_q ? wdata_q[{beat_next, 3'b000} +: 8] : 8'h00;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Bus-side initiator that turns the CPU datapath's 32-bit load/store requests into byte-wide accesses to the byte-organised DRAM. It sits between the load/store stage and the DRAM component on the motherboard. Byte, halfword and word accesses are serialised into one DRAM beat per byte, little-endian. Load data is sign- or zero-extended before it is returned.

## Interface
- ADDR_WIDTH, 32: address width of request and DRAM ports
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and accepting
- req_addr  in  ADDR_WIDTH  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0)
- req_wdata  in  32  store data; low bytes used for byte/half
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request
- mem_addr  out  ADDR_WIDTH  DRAM address; byte k is at k<<2 (DRAM decodes addr[ADDR_WIDTH-1:2])
- mem_wdata  out  8  byte to write
- mem_we  out  1  DRAM write enable; commit on rising edge
- mem_rdata  in  8  DRAM read data, combinational from mem_addr

## Operation
- States: IDLE, ACCESS, DONE. Async reset forces IDLE.
- IDLE: req_ready=1 when rst is low. On req_valid at the rising edge, latch addr, write, size, signed and wdata. Clear beat counter. Set N = 1, 2 or 4.
- Error check at accept: size=11, half with addr[0]≠0, or word with addr[1:0]≠0. On error go straight to DONE with resp_err=1. No DRAM beat, mem_we stays 0.
- ACCESS: beat b in 0..N-1.
  - mem_addr = ((addr + b) << 2), truncated to ADDR_WIDTH.
  - Store: mem_we=1, mem_wdata = wdata[8b+7:8b].
  - Load: mem_we=0, mem_rdata captured into byte lane b at the rising edge.
  - After beat N-1, go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Load result:
  - byte: bits [7:0], extended from bit 7.
  - half: bits [15:0], extended from bit 15.
  - word: unchanged.
  - Upper bits are 0 when req_signed=0.
- Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: all outputs return to reset values immediately and the request is dropped. DRAM bytes already committed stay written. No resp_valid is issued for the dropped request.

## Timing
- Reset values: req_ready=0 while rst is high, 1 once released. resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request accepted at edge E0. Beats occupy the cycles between E0..EN, and beat b commits or captures at edge E(b+1). resp_valid is high in the cycle after EN. req_ready returns the following cycle.
- Latency from accept edge to resp_valid: byte 1+1, half 2+1, word 4+1 cycles. Error case: resp_valid in the cycle immediately after E0.
- Throughput: one request per N+2 cycles. req_ready is low in ACCESS and DONE, and req_valid is ignored there.
- resp_rdata and resp_err are valid only while resp_valid=1. They are held at 0 otherwise.

## Structure
- Shared package mem_pkg holds:
  - size encodings SIZE_BYTE/HALF/WORD/RSVD
  - FSM state encoding
  - byte-lane shift constant 2 for DRAM address mapping
- One natural sub-module: load_extend, combinational (size, signed, 32-bit raw → 32-bit extended).
- Everything else (FSM, counter, registers) lives in mem_access_unit.

## Test plan
- Word store 0xDEADBEEF at 0x10 → mem_addr 0x40, 0x44, 0x48, 0x4C with mem_wdata EF, BE, AD, DE on consecutive cycles. resp_valid 5 cycles after accept with resp_err=0. A following word load from 0x10 returns 0xDEADBEEF.
- Byte 0x80 at address 0x7:
  - signed byte load → 0xFFFFFF80.
  - unsigned byte load → 0x00000080.
  - Each responds 2 cycles after accept.
- Half store 0x1234 at 0x2, then signed half load → 0x00001234.
- With 0x8001 stored at 0x2, signed half load → 0xFFFF8001.
- Half load at 0x3, word store at 0x6, and size=11 → each gives resp_err=1 and resp_rdata=0 one cycle after accept. mem_we never asserts.
- Word store of 0xAABBCCDD at 0x20, rst asserted after 2 beats:
  - outputs drop to reset values at once.
  - no resp_valid for that request.
  - bytes 0x20/0x21 hold DD/CC and 0x22/0x23 are unchanged.
  - the next request after release completes normally.
- req_valid held high back-to-back with two byte loads → req_ready low in ACCESS/DONE. The second request is accepted exactly 3 cycles after the first.
